// File: rtl/freq_mode_detector_if.sv
// Signal bundle for freq_mode_detector: measured input plus recovered mode/status.
// The slave modport is the detector; the master modport is whoever drives sig_in and consumes results.
interface freq_mode_detector_if #(
  parameter int unsigned CNT_W = 32
);
  logic             sig_in;
  logic             fm_out;
  logic             valid;
  logic [CNT_W-1:0] period;
  logic             meas_done;
  logic             lost;

  modport master (
    output sig_in,
    input  fm_out, valid, period, meas_done, lost
  );

  modport slave (
    input  sig_in,
    output fm_out, valid, period, meas_done, lost
  );
endinterface

// File: rtl/freq_mode_detector.sv
// Measures the period of a slow divided clock, classifies it as FM=0/FM=1 and locks after LOCK_CNT agreeing periods.
// Optional DEGLITCH_EN: 3-flop majority filter that suppresses single-cycle pulses/gaps before edge detection.
module freq_mode_detector #(
  parameter int unsigned PERIOD0  = 12500000,
  parameter int unsigned PERIOD1  = 50000000,
  parameter int unsigned TOL      = 1250000,
  parameter int unsigned LOCK_CNT = 2,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                 cin,
  input  logic                 rst_n,
  freq_mode_detector_if.slave  bus
);

  localparam logic [CNT_W-1:0] TMO  = CNT_W'(PERIOD1 + 2 * TOL);
  localparam logic [CNT_W-1:0] LO0  = CNT_W'(PERIOD0 - TOL);
  localparam logic [CNT_W-1:0] HI0  = CNT_W'(PERIOD0 + TOL);
  localparam logic [CNT_W-1:0] LO1  = CNT_W'(PERIOD1 - TOL);
  localparam logic [CNT_W-1:0] HI1  = CNT_W'(PERIOD1 + TOL);
  localparam logic [3:0]       LOCK = 4'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

  state_t           r_state, w_state_nx;
  logic             r_sync1, r_sync2, r_sig_d;
  logic             w_level, w_rise;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [3:0]       r_match, w_match_nx, w_match_inc;
  logic             r_cls, w_cls_nx;
  logic             r_fm, w_fm_nx;
  logic             r_valid, w_valid_nx;
  logic [CNT_W-1:0] r_period, w_period_nx;
  logic             r_meas, w_meas_nx;
  logic             r_lost, w_lost_nx;
  logic             w_in0, w_in1;

`ifdef DEGLITCH_EN
  logic [1:0] r_dg;
  logic       r_filt;

  // Majority of three consecutive samples, registered: single-cycle pulses never win the vote.
  always_ff @(posedge cin or negedge rst_n) begin
    if (!rst_n) begin
      r_dg   <= '0;
      r_filt <= 1'b0;
    end else begin
      r_dg   <= {r_dg[0], r_sync2};
      r_filt <= (r_sync2 & r_dg[0]) | (r_sync2 & r_dg[1]) | (r_dg[0] & r_dg[1]);
    end
  end

  assign w_level = r_filt;
`else
  assign w_level = r_sync2;
`endif

  assign w_rise = w_level & ~r_sig_d;
  assign w_in0  = (r_cnt >= LO0) && (r_cnt <= HI0);
  assign w_in1  = (r_cnt >= LO1) && (r_cnt <= HI1);

  // A fresh run starts at 1 whenever no run is pending or the class changed.
  assign w_match_inc = ((r_match == 4'd0) || (w_in1 != r_cls)) ? 4'd1 :
                       (r_match >= LOCK) ? LOCK : r_match + 4'd1;

  always_ff @(posedge cin or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sig_d  <= 1'b0;
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_match  <= '0;
      r_cls    <= 1'b0;
      r_fm     <= 1'b0;
      r_valid  <= 1'b0;
      r_period <= '0;
      r_meas   <= 1'b0;
      r_lost   <= 1'b0;
    end else begin
      r_sync1  <= bus.sig_in;
      r_sync2  <= r_sync1;
      r_sig_d  <= w_level;
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_match  <= w_match_nx;
      r_cls    <= w_cls_nx;
      r_fm     <= w_fm_nx;
      r_valid  <= w_valid_nx;
      r_period <= w_period_nx;
      r_meas   <= w_meas_nx;
      r_lost   <= w_lost_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_match_nx  = r_match;
    w_cls_nx    = r_cls;
    w_fm_nx     = r_fm;
    w_valid_nx  = r_valid;
    w_period_nx = r_period;
    w_meas_nx   = 1'b0;
    w_lost_nx   = 1'b0;

    if (w_rise)
      w_cnt_nx = CNT_W'(1);
    else if (r_cnt != TMO)
      w_cnt_nx = r_cnt + 1'b1;
    else
      w_cnt_nx = r_cnt;

    case (r_state)
      IDLE: begin
        if (w_rise)
          w_state_nx = MEASURE;
      end
      MEASURE, LOCKED: begin
        if (r_cnt == TMO) begin
          // A rise coinciding with timeout restarts measurement without capturing a period.
          w_lost_nx  = 1'b1;
          w_valid_nx = 1'b0;
          w_match_nx = '0;
          w_state_nx = w_rise ? MEASURE : IDLE;
        end else if (w_rise) begin
          w_meas_nx   = 1'b1;
          w_period_nx = r_cnt;
          if (!(w_in0 || w_in1)) begin
            w_match_nx = '0;
            w_valid_nx = 1'b0;
            w_state_nx = MEASURE;
          end else if (r_state == LOCKED) begin
            if (w_in1 != r_cls) begin
              w_valid_nx = 1'b0;
              w_match_nx = 4'd1;
              w_cls_nx   = w_in1;
              w_state_nx = MEASURE;
            end
          end else begin
            w_match_nx = w_match_inc;
            w_cls_nx   = w_in1;
            if (w_match_inc == LOCK) begin
              w_fm_nx    = w_in1;
              w_valid_nx = 1'b1;
              w_state_nx = LOCKED;
            end
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign bus.fm_out    = r_fm;
  assign bus.valid     = r_valid;
  assign bus.period    = r_period;
  assign bus.meas_done = r_meas;
  assign bus.lost      = r_lost;

endmodule
